// File: rtl/cargador_ventana_if.sv
// Bundle for the 5x5 window loader: request/ack side,
// memory read port and the captured window.
interface cargador_ventana_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       base_addr;
    logic [WIDTH-1:0]       stride;
    logic                   pause;
    logic                   ack;
    logic                   mem_rd;
    logic [WIDTH-1:0]       mem_addr;
    logic [WIDTH-1:0]       mem_data;
    logic                   busy;
    logic                   valid;
    logic [24:0][WIDTH-1:0] d;

    modport slave (
        input  start, base_addr, stride, pause, ack, mem_data,
        output mem_rd, mem_addr, busy, valid, d
    );

    modport master (
        output start, base_addr, stride, pause, ack, mem_data,
        input  mem_rd, mem_addr, busy, valid, d
    );
endinterface

// File: rtl/cargador_ventana.sv
// Loads a 5x5 pixel window from word memory, row-major,
// and holds it until the consumer acknowledges.
module cargador_ventana #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    cargador_ventana_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0] LAST_IDX = 5'd24;
    localparam logic [2:0] LAST_COL = 3'd4;

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       stride_q, stride_d;
    logic [WIDTH-1:0]       row_base_q, row_base_d;
    logic [WIDTH-1:0]       addr_q, addr_d;
    logic [2:0]             col_q, col_d;
    logic [4:0]             rd_idx_q, rd_idx_d;
    logic [4:0]             cap_idx_q, cap_idx_d;
    logic                   pend_q, pend_d;
    logic [24:0][WIDTH-1:0] win_q, win_d;
    logic                   rd;
    logic                   load;

    assign rd   = (state_q == S_FETCH) && !bus.pause;
    assign load = bus.start &&
                  ((state_q == S_IDLE) ||
                   ((state_q == S_DONE) && bus.ack));

    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        col_d      = col_q;
        rd_idx_d   = rd_idx_q;
        win_d      = win_q;
        pend_d     = rd;
        cap_idx_d  = rd ? rd_idx_q : cap_idx_q;

        // data returns one cycle after its strobe, tagged by cap_idx_q
        if (pend_q) begin
            win_d[cap_idx_q] = bus.mem_data;
        end

        unique case (1'b1)
            load: begin
                state_d    = S_FETCH;
                stride_d   = bus.stride;
                row_base_d = bus.base_addr;
                addr_d     = bus.base_addr;
                col_d      = 3'd0;
                rd_idx_d   = 5'd0;
            end
            rd: begin
                rd_idx_d = rd_idx_q + 5'd1;
                if (rd_idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end else if (col_q == LAST_COL) begin
                    col_d      = 3'd0;
                    row_base_d = row_base_q + stride_q;
                    addr_d     = row_base_q + stride_q;
                end else begin
                    col_d  = col_q + 3'd1;
                    addr_d = addr_q + WIDTH'(1);
                end
            end
            (state_q == S_DRAIN): begin
                state_d = S_DONE;
            end
            ((state_q == S_DONE) && bus.ack && !bus.start): begin
                state_d = S_IDLE;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            stride_q   <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            col_q      <= '0;
            rd_idx_q   <= '0;
            cap_idx_q  <= '0;
            pend_q     <= 1'b0;
            win_q      <= '0;
        end else begin
            state_q    <= state_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            rd_idx_q   <= rd_idx_d;
            cap_idx_q  <= cap_idx_d;
            pend_q     <= pend_d;
            win_q      <= win_d;
        end
    end

    assign bus.mem_rd   = rd;
    assign bus.mem_addr = addr_q;
    assign bus.busy     = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign bus.valid    = (state_q == S_DONE);
    assign bus.d        = win_q;
endmodule

// File: tb/tb_cargador_ventana.sv
// Randomized bench for cargador_ventana against a
// closed-form address/window model.
module tb_cargador_ventana;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] salt = '0;
    int           n_chk = 0;
    int           n_err = 0;

    cargador_ventana_if #(.WIDTH(W)) bus ();

    cargador_ventana #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] memf(input logic [W-1:0] a);
        return a ^ salt;
    endfunction

    // one-cycle read latency memory
    always @(posedge clk)
        bus.mem_data <= bus.mem_rd ? memf(bus.mem_addr) : 32'hDEAD_BEEF;

    function automatic logic [W-1:0] exp_addr(
        input logic [W-1:0] b, input logic [W-1:0] s, input int k);
        return b + W'(k / 5) * s + W'(k % 5);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_mem_rd"}, W'(bus.mem_rd), 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_busy"}, W'(bus.busy), 0);
        chk({tag, "_valid"}, W'(bus.valid), 0);
        for (int k = 0; k < 25; k++)
            chk($sformatf("%s_d%0d", tag, k), bus.d[k], 0);
    endtask

    task automatic check_window(input string tag, input logic [W-1:0] b,
                                input logic [W-1:0] s);
        for (int k = 0; k < 25; k++)
            chk($sformatf("%s_d%0d", tag, k), bus.d[k],
                memf(exp_addr(b, s, k)));
    endtask

    task automatic launch(input logic [W-1:0] b, input logic [W-1:0] s,
                          input bit with_ack);
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.stride    = s;
        bus.ack       = with_ack;
        tick;
        bus.start = 1'b0;
        bus.ack   = 1'b0;
    endtask

    // cycle 1 follows the start edge; ends at the negedge of the valid cycle
    task automatic run_fetch(input logic [W-1:0] b, input logic [W-1:0] s,
                             input int pct, input int p_from,
                             input int p_len, output int valid_cyc);
        int n = 0;
        int c = 1;
        while (n < 25 && c < 200) begin
            bus.pause = ((c >= p_from) && (c < p_from + p_len)) ||
                        ($urandom_range(0, 99) < pct);
            bus.start     = 1'($urandom_range(0, 1));
            bus.ack       = 1'($urandom_range(0, 1));
            bus.base_addr = $urandom;
            @(negedge clk);
            chk("fetch_busy", W'(bus.busy), 1);
            chk("fetch_valid", W'(bus.valid), 0);
            chk("fetch_mem_rd", W'(bus.mem_rd), W'(!bus.pause));
            if (!bus.pause) begin
                chk($sformatf("mem_addr%0d", n), bus.mem_addr,
                    exp_addr(b, s, n));
                n++;
            end
            tick;
            c++;
        end
        if (n != 25) chk("fetch_timeout", W'(n), 25);
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        bus.pause = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("drain_busy", W'(bus.busy), 1);
        chk("drain_valid", W'(bus.valid), 0);
        chk("drain_mem_rd", W'(bus.mem_rd), 0);
        tick;
        c++;
        bus.pause = 1'b0;
        @(negedge clk);
        chk("done_valid", W'(bus.valid), 1);
        chk("done_busy", W'(bus.busy), 0);
        chk("done_mem_rd", W'(bus.mem_rd), 0);
        check_window("win", b, s);
        valid_cyc = c;
    endtask

    task automatic hold_done(input logic [W-1:0] b, input logic [W-1:0] s,
                             input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.start     = 1'($urandom_range(0, 1));
            bus.base_addr = $urandom;
            bus.stride    = $urandom;
            bus.pause     = 1'($urandom_range(0, 1));
            bus.ack       = 1'b0;
            tick;
            @(negedge clk);
            chk("hold_valid", W'(bus.valid), 1);
            chk("hold_busy", W'(bus.busy), 0);
            check_window("hold", b, s);
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
    endtask

    task automatic release_win;
        bus.ack   = 1'b1;
        bus.start = 1'b0;
        tick;
        bus.ack = 1'b0;
        @(negedge clk);
        chk("rel_valid", W'(bus.valid), 0);
        chk("rel_busy", W'(bus.busy), 0);
    endtask

    initial begin
        int           vc;
        logic [W-1:0] b;
        logic [W-1:0] s;
        bit           in_done;

        bus.start     = 1'b0;
        bus.ack       = 1'b0;
        bus.pause     = 1'b0;
        bus.base_addr = '0;
        bus.stride    = '0;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        check_zero("reset");

        // ack and pause while idle do nothing
        bus.ack   = 1'b1;
        bus.pause = 1'b1;
        tick;
        bus.ack   = 1'b0;
        bus.pause = 1'b0;
        check_zero("idle_ack");

        // basic load, word[a] = a
        salt = '0;
        launch(100, 64, 1'b0);
        run_fetch(100, 64, 0, 0, 0, vc);
        chk("basic_lat", W'(vc), 27);
        chk("basic_d0", bus.d[0], 100);
        chk("basic_d6", bus.d[6], 165);
        chk("basic_d24", bus.d[24], 360);
        release_win;

        // three paused cycles after the 7th read
        launch(100, 64, 1'b0);
        run_fetch(100, 64, 0, 8, 3, vc);
        chk("pause_lat", W'(vc), 30);
        chk("pause_d7", bus.d[7], 166);
        release_win;

        // address wrap
        salt = $urandom;
        launch(32'hFFFF_FFFE, 1, 1'b0);
        run_fetch(32'hFFFF_FFFE, 1, 0, 0, 0, vc);
        chk("wrap_lat", W'(vc), 27);
        chk("wrap_d2", bus.d[2], memf(0));

        // long hold, then ack together with a new start
        hold_done(32'hFFFF_FFFE, 1, 10);
        s = $urandom;
        launch(0, s, 1'b1);
        run_fetch(0, s, 0, 0, 0, vc);
        chk("b2b_lat", W'(vc), 27);
        release_win;

        // reset on the 12th read
        b = $urandom;
        s = $urandom;
        launch(b, s, 1'b0);
        repeat (11) tick;
        rst = 1'b1;
        @(negedge clk);
        chk("rst12_mem_rd", W'(bus.mem_rd), 1);
        chk("rst12_addr", bus.mem_addr, exp_addr(b, s, 11));
        tick;
        rst = 1'b0;
        check_zero("rst_mid");
        tick;
        check_zero("rst_late");
        launch(b, s, 1'b0);
        run_fetch(b, s, 0, 0, 0, vc);
        chk("rst_relat", W'(vc), 27);
        in_done = 1'b1;

        // random loads with random pauses and handshakes
        for (int i = 0; i < 10; i++) begin
            bit b2b;
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) release_win;
            salt = $urandom;
            b    = $urandom;
            s    = (i % 3 == 0) ? W'($urandom_range(0, 8)) : W'($urandom);
            launch(b, s, b2b);
            run_fetch(b, s, 30, 0, 0, vc);
            hold_done(b, s, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
